// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-master memory arbiter.
//   state_t  : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   region_t : result of the 16-bit address decode
//   ROM_BASE / RAM_TOP : address map boundaries
//   UNMAPPED_DATA      : value returned for reads of unmapped space
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_ROM  = 2'd1,
        REG_NONE = 2'd2
    } region_t;

    localparam logic [15:0] ROM_BASE      = 16'hC000;
    localparam logic [15:0] RAM_TOP       = 16'h7FFF;
    localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

    // One-hot vector for a master index (0 = CPU, 1 = debug reader).
    function automatic logic [1:0] master_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// ---------------------------------------------------------------------------
// mem_addr_decode
// Purely combinational decode of a 16-bit CPU-space address.
//   addr   (in,  16)       : byte address
//   region (out, region_t) : REG_RAM for $0000-$7FFF, REG_ROM for $C000-$FFFF,
//                            REG_NONE for the $8000-$BFFF hole
// ---------------------------------------------------------------------------
module mem_addr_decode
    import mem_arb_pkg::*;
(
    input  logic [15:0] addr,
    output region_t     region
);

    always_comb begin
        region = REG_NONE;
        if (addr <= RAM_TOP) begin
            region = REG_RAM;
        end else if (addr >= ROM_BASE) begin
            region = REG_ROM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter giving a CPU (master 0) and a debug reader (master 1)
// access to a combinational ROM and a 1-cycle-latency RAM. One transaction
// every three cycles: IDLE (decision) -> ACCESS -> RESP -> IDLE.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   m_req[1:0]              : per-master request
//   m_addr[1:0][15:0]       : per-master address
//   m_we[1:0], m_wdata      : per-master write enable / write data
//   m_gnt[1:0]              : one-cycle grant pulse (cycle N+1)
//   m_done[1:0]             : one-cycle completion pulse (cycle N+3)
//   m_rdata, m_err          : read data / error, valid with m_done
//   rom_addr, rom_cs, rom_oe, rom_data           : ROM port
//   ram_addr, ram_cs, ram_we, ram_wdata, ram_rdata : RAM port
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ROM_AW = 14,
    parameter int RAM_AW = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           m_req,
    input  logic [1:0][15:0]     m_addr,
    input  logic [1:0]           m_we,
    input  logic [1:0][7:0]      m_wdata,
    output logic [1:0]           m_gnt,
    output logic [1:0]           m_done,
    output logic [7:0]           m_rdata,
    output logic                 m_err,
    output logic [ROM_AW-1:0]    rom_addr,
    output logic                 rom_cs,
    output logic                 rom_oe,
    input  logic [7:0]           rom_data,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata
);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t              state_q;
    region_t             region_q;
    logic                owner_q;
    logic                we_q;
    logic                rr_q;        // master that wins the next contention
    logic [1:0]          gnt_q;
    logic [1:0]          done_q;
    logic [7:0]          rdata_q;
    logic                err_q;
    logic [ROM_AW-1:0]   rom_addr_q;
    logic                rom_cs_q;
    logic                rom_oe_q;
    logic [RAM_AW-1:0]   ram_addr_q;
    logic                ram_cs_q;
    logic                ram_we_q;
    logic [7:0]          ram_wdata_q;

    // ------------------------------------------------------------------
    // Winner selection (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic                winner_d;
    logic [15:0]         sel_addr_d;
    logic                sel_we_d;
    logic [7:0]          sel_wdata_d;
    region_t             sel_region_d;

    always_comb begin
        winner_d = 1'b0;
        if (m_req == 2'b11) begin
            winner_d = rr_q;
        end else if (m_req[1]) begin
            winner_d = 1'b1;
        end
        sel_addr_d  = m_addr[winner_d];
        sel_we_d    = m_we[winner_d];
        sel_wdata_d = m_wdata[winner_d];
    end

    mem_addr_decode u_decode (
        .addr   (sel_addr_d),
        .region (sel_region_d)
    );

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            region_q    <= REG_NONE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            rr_q        <= 1'b0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            rom_addr_q  <= '0;
            rom_cs_q    <= 1'b0;
            rom_oe_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 8'h00;
        end else begin
            // Pulse outputs default low; ram_we only ever lives for ACCESS.
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 1'b0;
            ram_we_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (|m_req) begin
                        state_q     <= ACCESS;
                        owner_q     <= winner_d;
                        rr_q        <= ~winner_d;
                        gnt_q       <= master_onehot(winner_d);
                        we_q        <= sel_we_d;
                        region_q    <= sel_region_d;
                        rom_addr_q  <= sel_addr_d[ROM_AW-1:0];
                        ram_addr_q  <= sel_addr_d[RAM_AW-1:0];
                        ram_wdata_q <= sel_wdata_d;
                        // A write to ROM or any unmapped access selects nothing.
                        rom_cs_q    <= (sel_region_d == REG_ROM) && !sel_we_d;
                        rom_oe_q    <= (sel_region_d == REG_ROM) && !sel_we_d;
                        ram_cs_q    <= (sel_region_d == REG_RAM);
                        ram_we_q    <= (sel_region_d == REG_RAM) && sel_we_d;
                    end
                end

                ACCESS: begin
                    state_q <= RESP;
                end

                RESP: begin
                    // RAM read data has arrived by now; ROM data is combinational.
                    state_q  <= IDLE;
                    rom_cs_q <= 1'b0;
                    rom_oe_q <= 1'b0;
                    ram_cs_q <= 1'b0;
                    done_q   <= master_onehot(owner_q);
                    case (region_q)
                        REG_RAM: begin
                            if (!we_q) begin
                                rdata_q <= ram_rdata;
                            end
                        end
                        REG_ROM: begin
                            if (we_q) begin
                                err_q <= 1'b1;
                            end else begin
                                rdata_q <= rom_data;
                            end
                        end
                        default: begin
                            err_q <= 1'b1;
                            if (!we_q) begin
                                rdata_q <= UNMAPPED_DATA;
                            end
                        end
                    endcase
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_gnt     = gnt_q;
    assign m_done    = done_q;
    assign m_rdata   = rdata_q;
    assign m_err     = err_q;
    assign rom_addr  = rom_addr_q;
    assign rom_cs    = rom_cs_q;
    assign rom_oe    = rom_oe_q;
    assign ram_addr  = ram_addr_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed-vector bench for mem_arbiter with a behavioural ROM (driven by
// rom_val) and a 1-cycle-latency RAM model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic             clk;
    logic             rst_n;
    logic [1:0]       m_req;
    logic [1:0][15:0] m_addr;
    logic [1:0]       m_we;
    logic [1:0][7:0]  m_wdata;
    logic [1:0]       m_gnt;
    logic [1:0]       m_done;
    logic [7:0]       m_rdata;
    logic             m_err;
    logic [13:0]      rom_addr;
    logic             rom_cs;
    logic             rom_oe;
    logic [7:0]       rom_data;
    logic [14:0]      ram_addr;
    logic             ram_cs;
    logic             ram_we;
    logic [7:0]       ram_wdata;
    logic [7:0]       ram_rdata;

    logic [7:0]       rom_val;
    logic [7:0]       ram_mem [0:32767];

    int n_vec  = 0;
    int n_miss = 0;

    mem_arbiter #(.ROM_AW(14), .RAM_AW(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_req     (m_req),
        .m_addr    (m_addr),
        .m_we      (m_we),
        .m_wdata   (m_wdata),
        .m_gnt     (m_gnt),
        .m_done    (m_done),
        .m_rdata   (m_rdata),
        .m_err     (m_err),
        .rom_addr  (rom_addr),
        .rom_cs    (rom_cs),
        .rom_oe    (rom_oe),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = rom_val;

    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (ram_cs) ram_rdata <= ram_mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lone-master transaction issued in the current cycle (N); checks N+1..N+3.
    // exp_sel = {rom selected, ram selected}.
    task automatic xact(input int m, input logic [15:0] addr, input logic we,
                        input logic [7:0] wd, input logic [1:0] exp_sel,
                        input logic [7:0] exp_rdata, input logic exp_err);
        logic [31:0] onehot;
        onehot = (m == 0) ? 32'h1 : 32'h2;
        $display("xact m=%0d addr=%h we=%0d wdata=%h", m, addr, we, wd);
        m_req[m]   = 1'b1;
        m_addr[m]  = addr;
        m_we[m]    = we;
        m_wdata[m] = wd;
        step(); // N+1
        check("gnt_n1",    32'(m_gnt),  onehot);
        check("rom_cs_n1", 32'(rom_cs), 32'(exp_sel[1]));
        check("rom_oe_n1", 32'(rom_oe), 32'(exp_sel[1]));
        check("ram_cs_n1", 32'(ram_cs), 32'(exp_sel[0]));
        check("ram_we_n1", 32'(ram_we), 32'(exp_sel[0] & we));
        if (exp_sel[1]) check("rom_addr", 32'(rom_addr), 32'(addr[13:0]));
        if (exp_sel[0]) check("ram_addr", 32'(ram_addr), 32'(addr[14:0]));
        if (exp_sel[0] && we) check("ram_wdata", 32'(ram_wdata), 32'(wd));
        m_req[m] = 1'b0;
        step(); // N+2
        check("gnt_n2",    32'(m_gnt),  0);
        check("rom_cs_n2", 32'(rom_cs), 32'(exp_sel[1]));
        check("ram_cs_n2", 32'(ram_cs), 32'(exp_sel[0]));
        check("ram_we_n2", 32'(ram_we), 0);
        check("done_n2",   32'(m_done), 0);
        step(); // N+3
        check("done_n3",   32'(m_done),  onehot);
        check("rdata_n3",  32'(m_rdata), 32'(exp_rdata));
        check("err_n3",    32'(m_err),   32'(exp_err));
        check("sel_n3",    32'({rom_cs, ram_cs}), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        m_req   = 2'b00;
        m_addr  = '0;
        m_we    = 2'b00;
        m_wdata = '0;
        rom_val = 8'h00;

        // Reset state
        step();
        step();
        check("rst_gnt",   32'(m_gnt),     0);
        check("rst_done",  32'(m_done),    0);
        check("rst_rdata", 32'(m_rdata),   0);
        check("rst_err",   32'(m_err),     0);
        check("rst_sel",   32'({rom_cs, rom_oe, ram_cs, ram_we}), 0);
        check("rst_addrs", 32'({rom_addr, ram_addr}), 0);
        check("rst_wdata", 32'(ram_wdata), 0);
        rst_n = 1'b1;

        // ROM reads (first request accepted right after reset release)
        rom_val = 8'h00;
        xact(0, 16'hFFFC, 1'b0, 8'h00, 2'b10, 8'h00, 1'b0);
        rom_val = 8'hA5;
        xact(0, 16'hC123, 1'b0, 8'h00, 2'b10, 8'hA5, 1'b0);

        // RAM write then read back; write leaves m_rdata unchanged
        xact(0, 16'h0080, 1'b1, 8'h42, 2'b01, 8'hA5, 1'b0);
        xact(0, 16'h0080, 1'b0, 8'h00, 2'b01, 8'h42, 1'b0);
        // Top of RAM
        xact(0, 16'h7FFF, 1'b1, 8'h3C, 2'b01, 8'h42, 1'b0);
        xact(1, 16'h7FFF, 1'b0, 8'h00, 2'b01, 8'h3C, 1'b0);

        // ROM write and unmapped reads
        xact(1, 16'hC000, 1'b1, 8'hFF, 2'b00, 8'h3C, 1'b1);
        xact(1, 16'h8000, 1'b0, 8'h00, 2'b00, 8'hFF, 1'b1);
        xact(1, 16'hBFFF, 1'b0, 8'h00, 2'b00, 8'hFF, 1'b1);
        step();
        check("err_clear", 32'(m_err),  0);
        check("done_clr",  32'(m_done), 0);

        // Continuous contention from reset: CPU, DBG, CPU, DBG every 3 cycles
        rst_n     = 1'b0;
        m_req     = 2'b11;
        m_addr[0] = 16'hFFFC;
        m_addr[1] = 16'h0080;
        m_we      = 2'b00;
        step();
        step();
        rst_n = 1'b1;
        $display("xact contention CPU+DBG from reset");
        for (int k = 1; k <= 12; k++) begin
            logic [31:0] exp_gnt;
            step();
            exp_gnt = (k == 1 || k == 7) ? 32'h1 : (k == 4 || k == 10) ? 32'h2 : 32'h0;
            check($sformatf("rr_gnt_c%0d", k), 32'(m_gnt), exp_gnt);
            if (k == 3) check("rr_done_c3", 32'(m_done), 1);
            if (k == 6) check("rr_done_c6", 32'(m_done), 2);
        end
        m_req = 2'b00;
        step();
        step();
        step();

        // Reset during ACCESS of a CPU read
        $display("xact CPU read FFFC interrupted by reset");
        m_req[0]  = 1'b1;
        m_addr[0] = 16'hFFFC;
        m_we[0]   = 1'b0;
        step();
        check("abort_gnt",  32'(m_gnt),  1);
        check("abort_rom",  32'(rom_cs), 1);
        m_req = 2'b00;
        rst_n = 1'b0;
        #1;
        check("abort_clr_sel",  32'({rom_cs, rom_oe, ram_cs, ram_we}), 0);
        check("abort_clr_gnt",  32'(m_gnt),    0);
        check("abort_clr_addr", 32'(rom_addr), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("abort_no_done", 32'(m_done), 0);
        end
        rst_n = 1'b1;
        xact(1, 16'h0080, 1'b0, 8'h00, 2'b01, 8'h42, 1'b0);

        // CPU withdraws its request the cycle before it would have won
        $display("xact CPU drops req before grant while DBG requests");
        m_req     = 2'b10;
        m_addr[1] = 16'h0080;
        m_we      = 2'b00;
        step(); // A+1
        check("drop_gnt_a1", 32'(m_gnt), 2);
        m_req     = 2'b11;
        m_addr[0] = 16'hFFFC;
        step(); // A+2
        step(); // A+3
        check("drop_done_a3",  32'(m_done),  2);
        check("drop_rdata_a3", 32'(m_rdata), 8'h42);
        m_req = 2'b10;
        step(); // A+4
        check("drop_gnt_a4", 32'(m_gnt), 2);
        m_req = 2'b00;
        for (int k = 5; k <= 8; k++) begin
            step();
            check($sformatf("drop_no_cpu_a%0d", k), 32'(m_gnt[0]), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
